// File: rtl/key_cmd_pkg.sv
// Shared command codes, key indices, arbitration order and repeat mask
// for the Tetris key command scheduler.
package key_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_ROTATE = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_DOWN   = 3'd3,
    CMD_DROP   = 3'd4
  } cmd_t;

  localparam int unsigned NUM_KEYS   = 5;
  localparam int unsigned KEY_ROTATE = 0;
  localparam int unsigned KEY_LEFT   = 1;
  localparam int unsigned KEY_RIGHT  = 2;
  localparam int unsigned KEY_DOWN   = 3;
  localparam int unsigned KEY_DROP   = 4;

  // Keys that auto-repeat while held: left, right, down.
  localparam logic [NUM_KEYS-1:0] REPEAT_MASK = 5'b01110;

  // Highest priority first.
  localparam cmd_t PRIO_ORDER [NUM_KEYS] = '{CMD_DROP, CMD_ROTATE, CMD_DOWN, CMD_LEFT, CMD_RIGHT};

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO with flush; push while full is accepted
// only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [2:0] din,
  input  logic       pop,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [2:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gated so the head code reads 0 whenever the queue is empty, including reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Converts debounced button levels into an ordered command stream:
// press detection, DAS/ARR auto-repeat, pending bits, fixed-priority arbiter.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int unsigned DAS_DELAY  = 17_000_000,
  parameter int unsigned ARR_PERIOD = 5_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] key_level,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready
);

  localparam int unsigned CNT_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [NUM_KEYS-1:0] prev;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rpt_evt;
  logic [NUM_KEYS-1:0] events;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] clr_mask;
  logic [NUM_KEYS-1:0] rep;
  logic [NUM_KEYS-1:0] rep_nxt;
  logic [CW-1:0]       cnt     [NUM_KEYS];
  logic [CW-1:0]       cnt_nxt [NUM_KEYS];
  logic                lr_both;
  logic                grant_valid;
  cmd_t                grant_key;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;

  assign press   = key_level & ~prev;
  assign lr_both = key_level[KEY_LEFT] & key_level[KEY_RIGHT];

  // rep[k] selects the ARR interval once the first DAS repeat has fired.
  always_comb begin
    rpt_evt = '0;
    rep_nxt = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      cnt_nxt[k] = '0;
      if (REPEAT_MASK[k]) begin
        cnt_nxt[k] = cnt[k];
        rep_nxt[k] = rep[k];
        if (!key_level[k] || press[k] || (lr_both && (k == KEY_LEFT || k == KEY_RIGHT))) begin
          cnt_nxt[k] = '0;
          rep_nxt[k] = 1'b0;
        end else if ((32'(cnt[k]) + 32'd1) == (rep[k] ? ARR_PERIOD : DAS_DELAY)) begin
          rpt_evt[k] = 1'b1;
          cnt_nxt[k] = '0;
          rep_nxt[k] = 1'b1;
        end else if (cnt[k] != '1) begin
          cnt_nxt[k] = cnt[k] + CW'(1);
        end
      end
    end
  end

  assign events = (press | rpt_evt) & {NUM_KEYS{en}};

  always_comb begin
    grant_valid = 1'b0;
    grant_key   = CMD_ROTATE;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!grant_valid && pending[PRIO_ORDER[i]]) begin
        grant_valid = 1'b1;
        grant_key   = PRIO_ORDER[i];
      end
    end
  end

  assign pop      = cmd_valid && cmd_ready;
  assign push     = en && grant_valid && (!full || pop);
  assign clr_mask = push ? (NUM_KEYS'(1) << grant_key) : '0;

  // A new event on the key being granted this cycle survives as pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
      rep     <= '0;
      cnt     <= '{default: '0};
    end else if (!en) begin
      prev    <= key_level;
      pending <= '0;
      rep     <= '0;
      cnt     <= '{default: '0};
    end else begin
      prev    <= key_level;
      pending <= (pending & ~clr_mask) | events;
      rep     <= rep_nxt;
      cnt     <= cnt_nxt;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!en),
    .push  (push),
    .din   (3'(grant_key)),
    .pop   (pop),
    .dout  (cmd),
    .full  (full),
    .empty (empty)
  );

  assign cmd_valid = !empty;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with short DAS/ARR intervals.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [4:0] key_level = 5'b00001;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready = 1'b1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_cmd_scheduler #(
    .DAS_DELAY  (8),
    .ARR_PERIOD (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_level (key_level),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with en low, leaving the block flushed at cycle 0.
  task automatic clean_start();
    en = 1'b0; key_level = '0; cmd_ready = 1'b0;
    next_cycle();
    en = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      total++;
      if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
        bad++;
        $display("FAIL reset_state got valid=%b cmd=%0d exp valid=0 cmd=0", cmd_valid, cmd);
      end
    end
    // Rotate held while reset releases counts as a press at cycle 0.
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      key_level = (t == 0) ? 5'b00001 : 5'b00000;
      total++;
      if (cmd_valid !== (t == 2)) begin
        bad++;
        $display("FAIL held_through_reset t=%0d valid got=%b exp=%b", t, cmd_valid, t == 2);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_press();
    clean_start();
    for (int t = 0; t < 20; t++) begin
      key_level = (t == 10 || t == 11) ? 5'b00010 : 5'b00000;
      cmd_ready = 1'b1;
      total++;
      if (cmd_valid !== (t == 12)) begin
        bad++;
        $display("FAIL single_press t=%0d valid got=%b exp=%b", t, cmd_valid, t == 12);
      end
      if (t == 12) begin
        total++;
        if (cmd !== 3'd1) begin
          bad++;
          $display("FAIL single_press_cmd got=%0d exp=1", cmd);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_auto_repeat();
    logic ev;
    clean_start();
    for (int t = 0; t < 40; t++) begin
      key_level = (t >= 10 && t <= 29) ? 5'b00010 : 5'b00000;
      cmd_ready = 1'b1;
      ev = (t == 12 || t == 20 || t == 23 || t == 26 || t == 29);
      total++;
      if (cmd_valid !== ev) begin
        bad++;
        $display("FAIL auto_repeat t=%0d valid got=%b exp=%b", t, cmd_valid, ev);
      end
      if (ev) begin
        total++;
        if (cmd !== 3'd1) begin
          bad++;
          $display("FAIL auto_repeat_cmd t=%0d got=%0d exp=1", t, cmd);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_cmd [3];
    exp_cmd[0] = 3'd4; exp_cmd[1] = 3'd0; exp_cmd[2] = 3'd1;
    clean_start();
    for (int t = 0; t < 20; t++) begin
      key_level = (t == 10) ? 5'b10011 : 5'b00000;
      cmd_ready = 1'b1;
      total++;
      if (cmd_valid !== (t >= 12 && t <= 14)) begin
        bad++;
        $display("FAIL priority_valid t=%0d got=%b exp=%b", t, cmd_valid, t >= 12 && t <= 14);
      end
      if (t >= 12 && t <= 14) begin
        total++;
        if (cmd !== exp_cmd[t-12]) begin
          bad++;
          $display("FAIL priority_cmd t=%0d got=%0d exp=%0d", t, cmd, exp_cmd[t-12]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [5];
    logic       ev;
    logic [2:0] ec;
    seq[0] = 3'd4; seq[1] = 3'd0; seq[2] = 3'd3; seq[3] = 3'd1; seq[4] = 3'd2;
    clean_start();
    for (int t = 0; t < 30; t++) begin
      key_level = (t == 10) ? 5'b11111 : 5'b00000;
      cmd_ready = (t >= 20);
      ev = (t >= 12 && t <= 24);
      ec = (t < 20) ? 3'd4 : seq[(t >= 20 && t <= 24) ? t - 20 : 0];
      total++;
      if (cmd_valid !== ev) begin
        bad++;
        $display("FAIL full_backpressure_valid t=%0d got=%b exp=%b", t, cmd_valid, ev);
      end
      if (ev) begin
        total++;
        if (cmd !== ec) begin
          bad++;
          $display("FAIL full_backpressure_cmd t=%0d got=%0d exp=%0d", t, cmd, ec);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_left_right();
    logic       ev;
    clean_start();
    for (int t = 0; t < 46; t++) begin
      key_level = (t >= 10 && t <= 39) ? 5'b00110 : 5'b00000;
      cmd_ready = 1'b1;
      ev = (t == 12 || t == 13);
      total++;
      if (cmd_valid !== ev) begin
        bad++;
        $display("FAIL left_right_valid t=%0d got=%b exp=%b", t, cmd_valid, ev);
      end
      if (ev) begin
        total++;
        if (cmd !== ((t == 12) ? 3'd1 : 3'd2)) begin
          bad++;
          $display("FAIL left_right_cmd t=%0d got=%0d exp=%0d", t, cmd, (t == 12) ? 1 : 2);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_enable_flush();
    clean_start();
    for (int t = 0; t < 36; t++) begin
      key_level = (t >= 10) ? 5'b10111 : 5'b00000;
      cmd_ready = 1'b0;
      en = (t != 14);
      if (t == 14) begin
        total++;
        if (cmd_valid !== 1'b1) begin
          bad++;
          $display("FAIL enable_loaded got=%b exp=1", cmd_valid);
        end
      end
      if (t >= 15) begin
        total++;
        if (cmd_valid !== 1'b0) begin
          bad++;
          $display("FAIL enable_flush t=%0d valid got=%b exp=0", t, cmd_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    clean_start();
    for (int t = 0; t < 5; t++) begin
      key_level = (t == 0) ? 5'b10000 : 5'b00000;
      next_cycle();
    end
    total++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
      bad++;
      $display("FAIL async_reset_preload got valid=%b cmd=%0d exp valid=1 cmd=4", cmd_valid, cmd);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
      bad++;
      $display("FAIL async_reset_immediate got valid=%b cmd=%0d exp valid=0 cmd=0", cmd_valid, cmd);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_priority();
    test_back_to_back();
    test_left_right();
    test_enable_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
